// File: rtl/universal_sr_param_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// universal_sr_param_if : control/data bundle for universal_sr_param
// Rev 1.0
// ----------------------------------------------------------------------------
interface universal_sr_param_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] parin;
  logic             sin_r;
  logic             sin_l;
  logic [CW-1:0]    amt;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             sout_r;
  logic             sout_l;

  modport master (
    output en, sel, parin, sin_r, sin_l, amt, start,
    input  busy, done, out, sout_r, sout_l
  );

  modport slave (
    input  en, sel, parin, sin_r, sin_l, amt, start,
    output busy, done, out, sout_r, sout_l
  );
endinterface
`default_nettype wire

// File: rtl/universal_sr_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// universal_sr_param : WIDTH-bit universal shift register with burst engine
// Optional macro USR_ROTATE_EN enables ROTR (101) / ROTL (110).
// Rev 1.0
// ----------------------------------------------------------------------------
module universal_sr_param #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  wire logic           clk,
  input  wire logic           clr,
  universal_sr_param_if.slave bus
);

  localparam logic [2:0] c_HOLD = 3'b000;
  localparam logic [2:0] c_SHR  = 3'b001;
  localparam logic [2:0] c_SHL  = 3'b010;
  localparam logic [2:0] c_LOAD = 3'b011;
  localparam logic [2:0] c_ASR  = 3'b100;
  localparam logic [2:0] c_ROTR = 3'b101;
  localparam logic [2:0] c_ROTL = 3'b110;
  localparam logic [2:0] c_CLR  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             done_q;

  logic [2:0]       op_d;
  logic [WIDTH-1:0] out_d;
  logic             start_ok_d;

  always_comb begin
    start_ok_d = 1'b0;
    case (bus.sel)
      c_SHR, c_SHL, c_ASR: start_ok_d = 1'b1;
`ifdef USR_ROTATE_EN
      c_ROTR, c_ROTL:      start_ok_d = 1'b1;
`endif
      default:             start_ok_d = 1'b0;
    endcase
  end

  // During a burst the latched mode drives the datapath, not the live sel.
  always_comb begin
    op_d  = (state_q == RUN) ? mode_q : bus.sel;
    out_d = out_q;
    case (op_d)
      c_HOLD: out_d = out_q;
      c_SHR:  out_d = {bus.sin_r, out_q[WIDTH-1:1]};
      c_SHL:  out_d = {out_q[WIDTH-2:0], bus.sin_l};
      c_LOAD: out_d = bus.parin;
      c_ASR:  out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      c_ROTR: out_d = {out_q[0], out_q[WIDTH-1:1]};
      c_ROTL: out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
`else
      c_ROTR: out_d = out_q;
      c_ROTL: out_d = out_q;
`endif
      c_CLR:  out_d = '0;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      mode_q  <= c_HOLD;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && start_ok_d) begin
            mode_q  <= bus.sel;
            cnt_q   <= bus.amt;
            state_q <= RUN;
          end else if (bus.en) begin
            out_q <= out_d;
          end
        end
        RUN: begin
          // A zero count still spends one RUN cycle before signalling done.
          if (cnt_q != '0) begin
            out_q <= out_d;
            cnt_q <= cnt_q - CW'(1);
          end
          if (cnt_q <= CW'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.sout_r = out_q[0];
  assign bus.sout_l = out_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_universal_sr_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_universal_sr_param : directed self-checking bench for universal_sr_param
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_universal_sr_param;

  logic clk;
  logic clr;
  int   total;
  int   passed;

  universal_sr_param_if #(.WIDTH(8), .CW(4)) bus ();

  universal_sr_param #(.WIDTH(8), .CW(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.en = 1'b0; bus.start = 1'b0; bus.sel = 3'b000;
  endtask

  task automatic load(input logic [7:0] v);
    bus.en = 1'b1; bus.start = 1'b0; bus.sel = 3'b011; bus.parin = v;
    tick();
    idle_in();
  endtask

  initial begin
    total = 0; passed = 0;
    clr = 1'b1;
    bus.en = 1'b0; bus.sel = 3'b000; bus.parin = 8'h00;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.amt = 4'd0; bus.start = 1'b0;
    #1 clr = 1'b0;
    #11;
    chk("rst_out", bus.out, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    #1 clr = 1'b1;
    tick();

    // Single operations
    load(8'hB5);
    chk("load_b5", bus.out, 8'hB5);
    bus.en = 1'b1; bus.sel = 3'b001; bus.sin_r = 1'b1;
    tick();
    chk("shr", bus.out, 8'hDA);
    bus.sel = 3'b010; bus.sin_l = 1'b0;
    tick();
    chk("shl", bus.out, 8'hB4);
    bus.sel = 3'b111;
    tick();
    chk("sclr", bus.out, 8'h00);
    idle_in(); bus.sin_r = 1'b0;

    // Arithmetic shift right
    load(8'h80);
    chk("asr_sl0", bus.sout_l, 1'b1);
    bus.en = 1'b1; bus.sel = 3'b100;
    tick();
    chk("asr1", bus.out, 8'hC0);
    chk("asr_sl1", bus.sout_l, 1'b1);
    tick();
    chk("asr2", bus.out, 8'hE0);
    chk("asr_sl2", bus.sout_l, 1'b1);
    chk("asr_sr", bus.sout_r, 1'b0);
    idle_in();

    // Asynchronous reset mid-cycle
    load(8'hFF);
    chk("ff_loaded", bus.out, 8'hFF);
    chk("ff_sr", bus.sout_r, 1'b1);
    #3 clr = 1'b0;
    #1;
    chk("async_out", bus.out, 8'h00);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_done", bus.done, 1'b0);
    #1 clr = 1'b1;
    tick();

    // Burst of 3 with disturbances while busy
    load(8'h81);
`ifdef USR_ROTATE_EN
    bus.sel = 3'b101;
`else
    bus.sel = 3'b001;
`endif
    bus.sin_r = 1'b0; bus.amt = 4'd3; bus.start = 1'b1;
    tick();
    chk("b_accept_busy", bus.busy, 1'b1);
    chk("b_accept_out", bus.out, 8'h81);
    bus.en = 1'b1; bus.sel = 3'b011; bus.parin = 8'h00; bus.amt = 4'd9;
    tick();
`ifdef USR_ROTATE_EN
    chk("b_step1", bus.out, 8'hC0);
`else
    chk("b_step1", bus.out, 8'h40);
`endif
    chk("b_busy1", bus.busy, 1'b1);
    chk("b_done1", bus.done, 1'b0);
    tick();
`ifdef USR_ROTATE_EN
    chk("b_step2", bus.out, 8'h60);
`else
    chk("b_step2", bus.out, 8'h20);
`endif
    chk("b_busy2", bus.busy, 1'b1);
    idle_in();
    tick();
`ifdef USR_ROTATE_EN
    chk("b_step3", bus.out, 8'h30);
`else
    chk("b_step3", bus.out, 8'h10);
`endif
    chk("b_busy3", bus.busy, 1'b0);
    chk("b_done3", bus.done, 1'b1);
    tick();
    chk("b_done_off", bus.done, 1'b0);
`ifdef USR_ROTATE_EN
    chk("b_hold", bus.out, 8'h30);
`else
    chk("b_hold", bus.out, 8'h10);
`endif

    // Zero-count burst
    load(8'h3C);
    bus.sel = 3'b010; bus.amt = 4'd0; bus.start = 1'b1; bus.sin_l = 1'b1;
    tick();
    chk("z_busy", bus.busy, 1'b1);
    idle_in();
    tick();
    chk("z_busy_off", bus.busy, 1'b0);
    chk("z_done", bus.done, 1'b1);
    chk("z_out", bus.out, 8'h3C);
    tick();
    chk("z_done_off", bus.done, 1'b0);

    // Invalid start lets en through; valid start beats en
    bus.start = 1'b1; bus.en = 1'b1; bus.sel = 3'b011; bus.parin = 8'h55;
    tick();
    chk("inv_start_load", bus.out, 8'h55);
    chk("inv_start_busy", bus.busy, 1'b0);
    bus.sel = 3'b001; bus.sin_r = 1'b1; bus.amt = 4'd1;
    tick();
    chk("win_busy", bus.busy, 1'b1);
    chk("win_out", bus.out, 8'h55);
    idle_in();
    tick();
    chk("win_step", bus.out, 8'hAA);
    chk("win_done", bus.done, 1'b1);
    bus.sin_r = 1'b0;

    // Reset in the middle of a 5-step SHL burst
    load(8'h01);
    bus.sel = 3'b010; bus.sin_l = 1'b1; bus.amt = 4'd5; bus.start = 1'b1;
    tick();
    idle_in();
    tick();
    chk("mr_step1", bus.out, 8'h03);
    tick();
    chk("mr_step2", bus.out, 8'h07);
    #3 clr = 1'b0;
    #1;
    chk("mr_out", bus.out, 8'h00);
    chk("mr_busy", bus.busy, 1'b0);
    #1 clr = 1'b1;
    tick();
    chk("mr_nodone1", bus.done, 1'b0);
    tick();
    chk("mr_nodone2", bus.done, 1'b0);
    chk("mr_idle", bus.busy, 1'b0);
    bus.sin_l = 1'b0;

    // Rotate codes with and without the feature
    load(8'h81);
    bus.en = 1'b1; bus.sel = 3'b110;
    tick();
`ifdef USR_ROTATE_EN
    chk("rotl_en", bus.out, 8'h03);
`else
    chk("rotl_en", bus.out, 8'h81);
`endif
    idle_in();
    bus.start = 1'b1; bus.sel = 3'b101; bus.amt = 4'd2;
    tick();
`ifdef USR_ROTATE_EN
    chk("rotr_start", bus.busy, 1'b1);
`else
    chk("rotr_start", bus.busy, 1'b0);
`endif
    idle_in();
    tick(); tick(); tick();
    chk("final_idle", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/universal_sr_param.md
# universal_sr_param

Parametrised universal shift register: WIDTH-bit register with eight shift, rotate, load and clear modes, and serial in/out at both ends. Adds a multi-cycle burst engine that shifts by a programmed count with a start/busy/done handshake. Drop-in successor to the fixed 4-bit universal shift register, for serialiser, deserialiser and datapath-alignment use.

## Interface
- WIDTH, 8, register width (≥2)
- CW, 4, width of burst count `amt` (max burst 2^CW−1)

- clk  in  1  clock; rising edge active
- clr  in  1  asynchronous, active-low reset
- en  in  1  perform one `sel` operation this cycle (idle only)
- sel  in  3  mode code
- parin  in  WIDTH  parallel load data
- sin_r  in  1  serial bit entering MSB on shift right
- sin_l  in  1  serial bit entering LSB on shift left
- amt  in  CW  burst step count, sampled with `start`
- start  in  1  begin burst (idle only)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- out  out  WIDTH  register contents
- sout_r  out  1  = out[0] (combinational)
- sout_l  out  1  = out[WIDTH-1] (combinational)

## Operation
- sel codes, applied once per step:
  - 000 hold
  - 001 SHR (MSB ← sin_r)
  - 010 SHL (LSB ← sin_l)
  - 011 load `parin`
  - 100 ASR (MSB replicated)
  - 101 ROTR
  - 110 ROTL
  - 111 synchronous clear to 0
- Shift-class codes are 001, 010, 100, 101 and 110.
- FSM has two states, IDLE and RUN.
- IDLE:
  - `start`=1 with a shift-class `sel`: latch `sel` into the mode register, load `amt` into the counter, go to RUN. No data change on this edge.
  - `start` with a non-shift-class `sel` is ignored.
  - Otherwise, `en`=1 applies `sel` once.
  - `start` and `en` high together: a valid `start` wins and the `en` operation is dropped.
- RUN:
  - Each edge applies the latched mode once and decrements the counter.
  - After the step that brings the counter to 0, return to IDLE and assert `done`.
  - `amt`=0: one RUN cycle, no data change, then `done`.
- While busy, `en`, `start`, `sel`, `parin` and `amt` are ignored. `sin_r`/`sin_l` are sampled live on every step.
- Reset (`clr`=0, asynchronous): out=0, busy=0, done=0, state IDLE, counter 0.
  - Reset during a burst aborts it with no `done` pulse.
  - On release, the block is idle.

## Timing
- Single op: `en` sampled at edge T; `out` updates at T.
- Burst: `start` sampled at edge T; steps at edges T+1 … T+N, where N = max(amt,1).
- `busy` is high from after T until edge T+N. `done` is high for exactly the cycle after T+N, with `busy` low in that cycle.
- The earliest next `start` is accepted at edge T+N+1, the cycle in which `done` is high.
- `sout_r`/`sout_l` track `out` with no added latency.

## Configuration
- `USR_ROTATE_EN` defined: ROTR (101) and ROTL (110) implemented as above.
- Not defined:
  - 101 and 110 act as hold for `en`.
  - 101 and 110 are not shift-class, so `start` with either is ignored.

## Test plan
- Reset: drive clr=0 mid-cycle with out=0xFF → out=0x00, busy=0 and done=0 immediately, without waiting for a clock edge.
- Single ops:
  - en=1, sel=011, parin=0xB5 → 0xB5.
  - Then sel=001, sin_r=1 → 0xDA.
  - Then sel=010, sin_l=0 → 0xB4.
  - Then sel=111 → 0x00.
- ASR: load 0x80, then two en cycles with sel=100 → 0xC0, then 0xE0; sout_l=1 throughout.
- Burst (USR_ROTATE_EN defined): load 0x81, start with sel=101, amt=3 → out 0xC0, 0x60, 0x30 on successive edges.
  - busy high for exactly 3 cycles, then done high for 1 cycle.
  - A `start` or `en` issued while busy causes no change.
- amt=0 with start, sel=010, out=0x3C → busy for 1 cycle, done pulse, out stays 0x3C.
- Mid-burst reset: start SHL with amt=5, then clr=0 after 2 steps → out=0, busy=0, no done pulse.
- Macro off: en=1, sel=110 → out unchanged; start with sel=101 → busy stays 0.
